uart_autobaud: RTL and testbench

- Measures the bit period of an incoming UART sync character (0x55) on RX and produces the baud divisor consumed by the UART inside the 6502 test unit.
- Sits directly upstream of that UART, between the RX pin and the divisor input.
- Needed because the system clock comes from an uncalibrated ring oscillator, so the cycles-per-bit value cannot be a constant.

---
 rtl/uart_autobaud_pkg.sv | 20 ++
 rtl/uart_autobaud_rx_sync_edge.sv | 36 +++
 rtl/uart_autobaud.sv | 190 +++++++++++++++++++
 tb/tb_uart_autobaud.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_autobaud_pkg.sv
// uart_autobaud_pkg: state encoding and character constants shared by the autobaud block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_autobaud_pkg;

  typedef enum logic [1:0] {
    IDLE_WAIT  = 2'd0,
    WAIT_START = 2'd1,
    MEASURE    = 2'd2,
    LOCKED     = 2'd3
  } ab_state_e;

  // Sync character: LSB-first framing gives falling edges at start, b1, b3, b5, b7.
  localparam logic [7:0] SYNC_CHAR      = 8'h55;
  // Falling edges counted after the start edge before the 8-bit span is complete.
  localparam int         EDGES_PER_CHAR = 4;
  // The start-to-fifth-edge span covers 2**DIV_SHIFT bit times.
  localparam int         DIV_SHIFT      = 3;

endpackage

// File: rtl/uart_autobaud_rx_sync_edge.sv
// rx_sync_edge: 2-flop synchronizer plus history flop; emits level and edge strobes.
// Latency: level after 2 cycles, strobes visible after 2 cycles, acted on at the 3rd edge.
// Backpressure: none; free-running sampler. Rise strobe exists only with UART_AUTOBAUD_VERIFY_EN.
module rx_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic lvl_o,
  output logic fall_o
`ifdef UART_AUTOBAUD_VERIFY_EN
  , output logic rise_o
`endif
);

  logic s1_q, s2_q, prev_q;

  // Resync the pin and keep one cycle of history; reset to the idle (high) line level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= rx_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign lvl_o  = s2_q;
  assign fall_o = prev_q & ~s2_q;
`ifdef UART_AUTOBAUD_VERIFY_EN
  assign rise_o = ~prev_q & s2_q;
`endif

endmodule

// File: rtl/uart_autobaud.sv
// uart_autobaud: measures a 0x55 sync character on rx_in and latches the cycles-per-bit divisor.
// Latency: lock_pulse/err one cycle after the deciding edge is seen (pin + 3 cycles + 1).
// Backpressure: none; rearm restarts at any time. UART_AUTOBAUD_VERIFY_EN adds a start-bit low-time check.
module uart_autobaud
  import uart_autobaud_pkg::*;
#(
  parameter int CNT_W       = 20,
  parameter int IDLE_CYCLES = 64,
  parameter int MIN_DIV     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_in,
  input  logic             rearm,
  output logic [CNT_W-4:0] baud_div,
  output logic             locked,
  output logic             lock_pulse,
  output logic             err
);

  localparam int DIV_W  = CNT_W - DIV_SHIFT;
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  // The counter is cleared on the start edge, so it reads one less than the
  // edge-to-edge span when the final edge arrives; fold that +1 into the rounding.
  localparam logic [CNT_W:0] ROUND_K = (CNT_W+1)'(1 + (1 << (DIV_SHIFT - 1)));

  logic rx_lvl, rx_fall;
`ifdef UART_AUTOBAUD_VERIFY_EN
  logic rx_rise;
`endif

  rx_sync_edge u_sync (
    .clk_i  (clk),
    .rst_i  (reset),
    .rx_i   (rx_in),
    .lvl_o  (rx_lvl),
    .fall_o (rx_fall)
`ifdef UART_AUTOBAUD_VERIFY_EN
    , .rise_o (rx_rise)
`endif
  );

  ab_state_e        state_q, state_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       edge_q, edge_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             locked_q, locked_d;
  logic             lock_pulse_q, lock_pulse_d;
  logic             err_q, err_d;

  // Rounded divisor candidate, clamped so a near-saturated count cannot wrap.
  logic [CNT_W:0]          span_rnd;
  logic [CNT_W-DIV_SHIFT:0] div_wide;
  logic [DIV_W-1:0]        div_cand;
  logic                    div_ok, final_edge, cnt_sat, verify_ok;

  assign span_rnd   = {1'b0, cnt_q} + ROUND_K;
  assign div_wide   = span_rnd[CNT_W:DIV_SHIFT];
  assign div_cand   = div_wide[DIV_W] ? '1 : div_wide[DIV_W-1:0];
  assign div_ok     = div_cand >= DIV_W'(MIN_DIV);
  assign final_edge = rx_fall && (edge_q == 3'(EDGES_PER_CHAR - 1));
  assign cnt_sat    = &cnt_q;

`ifdef UART_AUTOBAUD_VERIFY_EN
  logic [CNT_W-1:0] low_q, low_d;
  logic             low_seen_q, low_seen_d;
  logic [CNT_W-1:0] div_ext, low_diff;

  assign div_ext   = CNT_W'(div_cand);
  assign low_diff  = (low_q >= div_ext) ? (low_q - div_ext) : (div_ext - low_q);
  assign verify_ok = low_seen_q && (low_diff <= (div_ext >> 2));

  // Start-bit low time, captured at the first rising edge of the measurement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      low_q      <= '0;
      low_seen_q <= 1'b0;
    end else begin
      low_q      <= low_d;
      low_seen_q <= low_seen_d;
    end
  end
`else
  assign verify_ok = 1'b1;
`endif

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE_WAIT;
      idle_q       <= '0;
      cnt_q        <= '0;
      edge_q       <= '0;
      div_q        <= '0;
      locked_q     <= 1'b0;
      lock_pulse_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idle_q       <= idle_d;
      cnt_q        <= cnt_d;
      edge_q       <= edge_d;
      div_q        <= div_d;
      locked_q     <= locked_d;
      lock_pulse_q <= lock_pulse_d;
      err_q        <= err_d;
    end
  end

  // Next-state and datapath: rearm overrides everything, including a final edge.
  always_comb begin
    state_d      = state_q;
    idle_d       = idle_q;
    cnt_d        = cnt_q;
    edge_d       = edge_q;
    div_d        = div_q;
    locked_d     = locked_q;
    lock_pulse_d = 1'b0;
    err_d        = 1'b0;
`ifdef UART_AUTOBAUD_VERIFY_EN
    low_d        = low_q;
    low_seen_d   = low_seen_q;
`endif
    if (rearm) begin
      state_d  = IDLE_WAIT;
      idle_d   = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE_WAIT: begin
          if (!rx_lvl) begin
            idle_d = '0;
          end else if (idle_q >= IDLE_W'(IDLE_CYCLES - 1)) begin
            idle_d  = '0;
            state_d = WAIT_START;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
        WAIT_START: begin
          if (rx_fall) begin
            cnt_d   = '0;
            edge_d  = '0;
            state_d = MEASURE;
`ifdef UART_AUTOBAUD_VERIFY_EN
            low_seen_d = 1'b0;
`endif
          end
        end
        MEASURE: begin
          if (!cnt_sat) cnt_d = cnt_q + 1'b1;
          if (rx_fall) edge_d = edge_q + 1'b1;
`ifdef UART_AUTOBAUD_VERIFY_EN
          if (rx_rise && !low_seen_q) begin
            low_d      = cnt_q + 1'b1;
            low_seen_d = 1'b1;
          end
`endif
          if (final_edge) begin
            if (div_ok && verify_ok) begin
              div_d        = div_cand;
              locked_d     = 1'b1;
              lock_pulse_d = 1'b1;
              state_d      = LOCKED;
            end else begin
              err_d   = 1'b1;
              idle_d  = '0;
              state_d = IDLE_WAIT;
            end
          end else if (cnt_sat) begin
            err_d   = 1'b1;
            idle_d  = '0;
            state_d = IDLE_WAIT;
          end
        end
        LOCKED: begin
          state_d = LOCKED;
        end
        default: state_d = IDLE_WAIT;
      endcase
    end
  end

  assign baud_div   = div_q;
  assign locked     = locked_q;
  assign lock_pulse = lock_pulse_q;
  assign err        = err_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// tb_uart_autobaud: scoreboard bench for uart_autobaud; lock/err events are queued when a frame is driven.
// Latency: events popped as soon as the DUT strobes lock_pulse or err.
// Backpressure: none. Built with or without UART_AUTOBAUD_VERIFY_EN.
module tb_uart_autobaud;
  import uart_autobaud_pkg::*;

  localparam int CNT_W  = 14;
  localparam int DIV_W  = CNT_W - 3;
  localparam int K_LOCK = 1;
  localparam int K_ERR  = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             rx_in = 1'b1;
  logic             rearm = 1'b0;
  logic [DIV_W-1:0] baud_div;
  logic             locked, lock_pulse, err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int kind;
    int div;
  } want_t;
  want_t sb[$];

  uart_autobaud #(.CNT_W(CNT_W), .IDLE_CYCLES(64), .MIN_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_in      (rx_in),
    .rearm      (rearm),
    .baud_div   (baud_div),
    .locked     (locked),
    .lock_pulse (lock_pulse),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, want);
    end
  endtask

  // Advance n clocks and settle 2 time units past the edge before driving.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_rearm();
    rearm = 1'b1;
    cyc(1);
    rearm = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    cyc(n);
  endtask

  // One 8N1 frame; bit edges after the start edge optionally jittered by -1..+1.
  task automatic send_frame(input logic [7:0] c, input int p, input int start_p, input bit jit);
    int   e [0:10];
    logic lv [0:9];
    e[0] = 0;
    for (int k = 1; k <= 9; k++) begin
      e[k] = start_p + (k - 1) * p;
      if (jit) e[k] = e[k] + int'($urandom_range(2, 0)) - 1;
    end
    e[10] = e[9] + p;
    lv[0] = 1'b0;
    for (int k = 0; k < 8; k++) lv[k+1] = c[k];
    lv[9] = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      rx_in = lv[k];
      cyc(e[k+1] - e[k]);
    end
    rx_in = 1'b1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check_eq(tag, sb.size(), 0);
    cyc(1);
  endtask

  // Scoreboard monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    want_t w;
    if (!reset && (lock_pulse || err)) begin
      check_eq("evt_excl", 32'(lock_pulse & err), 0);
      if (sb.size() == 0) begin
        check_eq("evt_unexpected", {30'd0, lock_pulse, err}, 0);
      end else begin
        w = sb.pop_front();
        check_eq("evt_kind", lock_pulse ? K_LOCK : K_ERR, w.kind);
        if (w.kind == K_LOCK) begin
          check_eq("evt_div", 32'(baud_div), w.div);
          check_eq("evt_locked", 32'(locked), 1);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_lock;
    // Reset state
    #1;
    check_eq("rst_div", 32'(baud_div), 0);
    check_eq("rst_locked", 32'(locked), 0);
    check_eq("rst_lock_pulse", 32'(lock_pulse), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_state", 32'(dut.state_q), 32'(IDLE_WAIT));
    cyc(1);
    reset = 1'b0;

    // 1: 16 cycles/bit
    idle(100);
    sb.push_back('{K_LOCK, 16});
    send_frame(SYNC_CHAR, 16, 16, 1'b0);
    wait_drain("t1_drain", 200);
    check_eq("t1_div", 32'(baud_div), 16);
    check_eq("t1_locked", 32'(locked), 1);

    // 2: 217 cycles/bit with jittered edges
    pulse_rearm();
    idle(100);
    sb.push_back('{K_LOCK, 217});
    send_frame(SYNC_CHAR, 217, 217, 1'b1);
    wait_drain("t2_drain", 500);
    check_eq("t2_div", 32'(baud_div), 217);

    // 3: 2 cycles/bit is below MIN_DIV
    do_reset();
    idle(100);
    sb.push_back('{K_ERR, 0});
    send_frame(SYNC_CHAR, 2, 2, 1'b0);
    wait_drain("t3_drain", 50);
    check_eq("t3_locked", 32'(locked), 0);
    check_eq("t3_div", 32'(baud_div), 0);
    check_eq("t3_state", 32'(dut.state_q), 32'(IDLE_WAIT));

    // 4: stuck-low line saturates the counter, then a good frame at 32
    idle(100);
    sb.push_back('{K_ERR, 0});
    rx_in = 1'b0;
    wait_drain("t4_sat_drain", 20000);
    check_eq("t4_locked", 32'(locked), 0);
    idle(100);
    sb.push_back('{K_LOCK, 32});
    send_frame(SYNC_CHAR, 32, 32, 1'b0);
    wait_drain("t4_drain", 300);
    check_eq("t4_div", 32'(baud_div), 32);

    // 5: lock at 16, rearm, relock at 48, then reset mid-measurement
    pulse_rearm();
    idle(100);
    sb.push_back('{K_LOCK, 16});
    send_frame(SYNC_CHAR, 16, 16, 1'b0);
    wait_drain("t5a_drain", 200);
    rearm = 1'b1;
    @(negedge clk);
    check_eq("t5_locked_pre", 32'(locked), 1);
    cyc(1);
    rearm = 1'b0;
    @(negedge clk);
    check_eq("t5_locked_drop", 32'(locked), 0);
    check_eq("t5_div_hold", 32'(baud_div), 16);
    cyc(1);
    idle(100);
    sb.push_back('{K_LOCK, 48});
    fork
      send_frame(SYNC_CHAR, 48, 48, 1'b0);
      begin
        cyc(48 * 4);
        check_eq("t5_div_mid", 32'(baud_div), 16);
      end
    join
    wait_drain("t5b_drain", 500);
    check_eq("t5_div_new", 32'(baud_div), 48);
    pulse_rearm();
    idle(100);
    fork
      send_frame(SYNC_CHAR, 48, 48, 1'b0);
      begin
        cyc(48 * 3);
        #1;
        reset = 1'b1;
        #1;
        check_eq("t5_rst_div", 32'(baud_div), 0);
        check_eq("t5_rst_locked", 32'(locked), 0);
        check_eq("t5_rst_flags", {30'd0, lock_pulse, err}, 0);
        check_eq("t5_rst_state", 32'(dut.state_q), 32'(IDLE_WAIT));
      end
    join
    cyc(1);
    reset = 1'b0;
    cyc(1);

    // 6: start bit stretched to 24, data at 16
`ifdef UART_AUTOBAUD_VERIFY_EN
    sb.push_back('{K_ERR, 0});
    exp_lock = 0;
`else
    sb.push_back('{K_LOCK, 17});
    exp_lock = 1;
`endif
    idle(100);
    send_frame(SYNC_CHAR, 16, 24, 1'b0);
    wait_drain("t6_drain", 200);
    check_eq("t6_locked", 32'(locked), exp_lock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
